// File: rtl/opb_regbank_pkg.sv
// opb_regbank_pkg
//   Shared constants for the OPB software-register bank: register offsets,
//   control bit position, status word field layout and channel limit, plus a
//   helper that assembles the control/status read word.
//   Compile this package before any file that imports it.
package opb_regbank_pkg;

   // Byte offsets inside the bank.
   localparam int REG_CTRL_OFS    = 0;
   localparam int REG_CH_BASE_OFS = 4;

   // Control write: numeric value bit that requests a software snapshot.
   localparam int CTRL_SNAP_BIT   = 0;

   // Status read word layout: {snap_count, 8'h00, num_ch}.
   localparam int STAT_NUM_CH_LSB = 0;
   localparam int STAT_NUM_CH_W   = 8;
   localparam int STAT_COUNT_LSB  = 16;
   localparam int STAT_COUNT_W    = 16;

   localparam int MAX_NUM_CH      = 32;

   function automatic logic [31:0] status_word(input logic [STAT_COUNT_W-1:0]  cnt,
                                               input logic [STAT_NUM_CH_W-1:0] num_ch);
      logic [31:0] w;
      w = '0;
      w[STAT_COUNT_LSB  +: STAT_COUNT_W]  = cnt;
      w[STAT_NUM_CH_LSB +: STAT_NUM_CH_W] = num_ch;
      return w;
   endfunction

endpackage

// File: rtl/opb_slave_ack_decode.sv
// opb_slave_ack_decode
//   Address window compare, byte-offset capture and one-cycle acknowledge
//   generation for a simple OPB slave register block.
//   Handshake: a transfer is requested while select_i is high with addr_i in
//   [C_BASEADDR, C_HIGHADDR]; ack_o is high for exactly one cycle, one cycle
//   after the request is first sampled. A request still held in the ack cycle
//   is not acked again; a request held beyond that gets a fresh ack.
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset
//   addr_i         OPB address (numeric, MSB first)
//   select_i       transfer request
//   rnw_i          1 = read, 0 = write
//   ack_o          transfer acknowledge (suppressed while rst_i is high)
//   rnw_o          direction of the transfer being acked
//   ofs_o          byte offset from C_BASEADDR of the transfer being acked
module opb_slave_ack_decode #(
   parameter int                  C_AWIDTH   = 32,
   parameter logic [C_AWIDTH-1:0] C_BASEADDR = '0,
   parameter logic [C_AWIDTH-1:0] C_HIGHADDR = '1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [C_AWIDTH-1:0] addr_i,
   input  logic                select_i,
   input  logic                rnw_i,
   output logic                ack_o,
   output logic                rnw_o,
   output logic [C_AWIDTH-1:0] ofs_o
);

   logic                hit;
   logic                ack_q, ack_d;
   logic                rnw_q, rnw_d;
   logic [C_AWIDTH-1:0] ofs_q, ofs_d;

   assign hit = select_i && (addr_i >= C_BASEADDR) && (addr_i <= C_HIGHADDR);

   always_comb begin
      ack_d = hit & ~ack_q;
      rnw_d = rnw_q;
      ofs_d = ofs_q;
      // Offset and direction are frozen for the ack cycle so the data path
      // only looks at registered state.
      if (ack_d) begin
         rnw_d = rnw_i;
         ofs_d = addr_i - C_BASEADDR;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_q <= 1'b0;
         rnw_q <= 1'b0;
         ofs_q <= '0;
      end else begin
         ack_q <= ack_d;
         rnw_q <= rnw_d;
         ofs_q <= ofs_d;
      end
   end

   // Reset cancels an ack that is already showing.
   assign ack_o = ack_q & ~rst_i;
   assign rnw_o = rnw_q;
   assign ofs_o = ofs_q;

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// opb_register_bank_simulink2ppc
//   Read-only bank of C_NUM_CH 32-bit user words on the OPB.
//   Offset 0x00: status {snap_count, 8'h00, C_NUM_CH}; write bit 0 = 1 requests
//   a snapshot. Offset 4*(i+1): channel i. Other in-window offsets read 0.
//   Optional feature macro OPB_REGBANK_SNAPSHOT_EN: all channels are captured
//   together on a software or fabric trigger and snap_count counts captures.
//   Without it the shadow follows user_data_in every cycle.
// Ports
//   OPB_Clk, OPB_Rst              clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW/select/seqAddr   OPB slave inputs (BE, seqAddr unused)
//   Sl_DBus, Sl_xferAck           read data (0 unless acking a read), ack
//   Sl_errAck, Sl_retry, Sl_toutSup       tied 0
//   user_data_in                  channel i at bits [32i+31:32i]
//   user_snap                     fabric trigger, level-sampled
//   snap_done                     pulse in the cycle after each capture
module opb_register_bank_simulink2ppc
   import opb_regbank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h01008300,
   parameter logic [31:0] C_HIGHADDR   = 32'h010083FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex5",
   parameter int          C_NUM_CH     = 4
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst,
   input  logic [0:31]             OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:31]             OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:31]             Sl_DBus,
   output logic                    Sl_xferAck,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   input  logic [32*C_NUM_CH-1:0]  user_data_in,
   input  logic                    user_snap,
   output logic                    snap_done
);

   if (C_OPB_DWIDTH != 32 || C_NUM_CH < 1 || C_NUM_CH > MAX_NUM_CH ||
       (C_HIGHADDR - C_BASEADDR) < 32'(4 * C_NUM_CH + 3)) begin : g_bad_cfg
      $error("opb_register_bank_simulink2ppc (%s): unsupported parameters", C_FAMILY);
   end

   logic                    ack;
   logic                    rnw_q;
   logic [31:0]             ofs_q;
   logic [32*C_NUM_CH-1:0]  shadow_q, shadow_d;
   logic [15:0]             cnt_q, cnt_d;
   logic                    done_q, done_d;
   logic [31:0]             rd_word;
   logic                    unused_inputs;

   opb_slave_ack_decode #(
      .C_AWIDTH   (C_OPB_AWIDTH),
      .C_BASEADDR (C_BASEADDR),
      .C_HIGHADDR (C_HIGHADDR)
   ) u_decode (
      .clk_i    (OPB_Clk),
      .rst_i    (OPB_Rst),
      .addr_i   (OPB_ABus),
      .select_i (OPB_select),
      .rnw_i    (OPB_RNW),
      .ack_o    (ack),
      .rnw_o    (rnw_q),
      .ofs_o    (ofs_q)
   );

`ifdef OPB_REGBANK_SNAPSHOT_EN
   logic sw_trig;
   logic capture;

   // Write data is held by the master through the ack cycle, so the trigger
   // lands on the edge that ends the ack.
   assign sw_trig = ack & ~rnw_q & (ofs_q == 32'(REG_CTRL_OFS)) &
                    OPB_DBus[31-CTRL_SNAP_BIT];
   // Both sources at once still make a single capture.
   assign capture = user_snap | sw_trig;

   always_comb begin
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      done_d   = capture;
      if (capture) begin
         shadow_d = user_data_in;
         cnt_d    = cnt_q + 16'd1;
      end
   end
`else
   always_comb begin
      shadow_d = user_data_in;
      cnt_d    = '0;
      done_d   = 1'b0;
   end
`endif

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         shadow_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
      end
   end

   // Read mux works on pre-edge state, so a read acked on a capture edge
   // returns the old shadow and the old count.
   always_comb begin
      rd_word = '0;
      if (ofs_q == 32'(REG_CTRL_OFS)) begin
         rd_word = status_word(cnt_q, 8'(C_NUM_CH));
      end
      for (int i = 0; i < C_NUM_CH; i++) begin
         if (ofs_q == 32'(REG_CH_BASE_OFS + 4 * i)) begin
            rd_word = shadow_q[32*i +: 32];
         end
      end
   end

   assign Sl_DBus    = (ack && rnw_q) ? rd_word : 32'h0;
   assign Sl_xferAck = ack;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;
   assign snap_done  = done_q;

   assign unused_inputs = ^{OPB_BE, OPB_seqAddr, OPB_DBus, user_snap};

endmodule
